insn_enc: RTL

Pipelined RISC-V RV32I instruction encoder, the inverse of the decode-side immediate generator. It accepts instruction fields (opcode, register indices, funct codes, and a full 32-bit immediate) over a valid/ready handshake. It range-checks the immediate for the opcode's format and emits the packed 32-bit instruction word. It sits in the test/boot infrastructure, feeding instruction memory preload and self-check benches. It also provides a handshake counter and a sticky error flag for software-visible status.

---
 rtl/insn_enc.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/insn_enc.sv
// insn_enc: RV32I instruction encoder. Packs fields plus a 32-bit immediate into an instruction word and flags range/opcode errors.
// Latency: two register stages. An input accepted at edge N is presented on valid_o after edge N+1.
// Backpressure: valid/ready on both sides. S1 holds one extra entry, and ready_o falls only when both stages are full and ready_i=0.
module insn_enc #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [DWIDTH-1:0] imm_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic              err_o,
  output logic [31:0]       enc_count_o,
  output logic              err_sticky_o,
  input  logic              clr_i
);

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Word emitted for an unrecognised opcode: addi x0, x0, 0
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  // Input-side decode
  fmt_e        fmt_in;
  logic        range_ok;

  // Stage 1: captured fields, format and check result
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q,   s1_fmt_d;
  logic        s1_err_q,   s1_err_d;
  logic [6:0]  s1_op_q,    s1_op_d;
  logic [4:0]  s1_rd_q,    s1_rd_d;
  logic [4:0]  s1_rs1_q,   s1_rs1_d;
  logic [4:0]  s1_rs2_q,   s1_rs2_d;
  logic [2:0]  s1_f3_q,    s1_f3_d;
  logic [6:0]  s1_f7_q,    s1_f7_d;
  logic [31:0] s1_imm_q,   s1_imm_d;

  // Stage 2: assembled word
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_insn_q,  s2_insn_d;
  logic        s2_err_q,   s2_err_d;
  logic [31:0] insn_asm;

  // Status
  logic [31:0] enc_count_q, enc_count_d;
  logic        err_sticky_q, err_sticky_d;

  // Handshake terms
  logic        en2;
  logic        in_accept;
  logic        s1_adv;
  logic        out_hs;

  assign en2       = !s2_valid_q || ready_i;
  assign ready_o   = !s1_valid_q || en2;
  assign in_accept = valid_i && ready_o;
  assign s1_adv    = s1_valid_q && en2;
  assign out_hs    = s2_valid_q && ready_i;

  assign valid_o      = s2_valid_q;
  assign insn_o       = s2_insn_q;
  assign err_o        = s2_err_q;
  assign enc_count_o  = enc_count_q;
  assign err_sticky_o = err_sticky_q;

  // Classify the incoming opcode into an encoding format
  always_comb begin
    fmt_in = FMT_BAD;
    case (opcode_i)
      OP_LUI, OP_AUIPC:                        fmt_in = FMT_U;
      OP_JAL:                                  fmt_in = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM,
      OP_SYSTEM, OP_MISC:                      fmt_in = FMT_I;
      OP_STORE:                                fmt_in = FMT_S;
      OP_BRANCH:                               fmt_in = FMT_B;
      OP_OP:                                   fmt_in = FMT_R;
      default:                                 fmt_in = FMT_BAD;
    endcase
  end

  // Check that the immediate fits the format (sign-extension bits all equal, alignment)
  always_comb begin
    range_ok = 1'b1;
    case (fmt_in)
      FMT_I, FMT_S: range_ok = (imm_i[31:11] == {21{imm_i[31]}});
      FMT_B:        range_ok = !imm_i[0] && (imm_i[31:12] == {20{imm_i[31]}});
      FMT_J:        range_ok = !imm_i[0] && (imm_i[31:20] == {12{imm_i[31]}});
      FMT_U:        range_ok = (imm_i[11:0] == 12'd0);
      FMT_R:        range_ok = 1'b1;
      default:      range_ok = 1'b0;
    endcase
  end

  // Stage 1 next state: load on accept, drain when handed to stage 2
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_err_d   = s1_err_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_f3_d    = s1_f3_q;
    s1_f7_d    = s1_f7_q;
    s1_imm_d   = s1_imm_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_fmt_d   = fmt_in;
      s1_err_d   = !range_ok;
      s1_op_d    = opcode_i;
      s1_rd_d    = rd_i;
      s1_rs1_d   = rs1_i;
      s1_rs2_d   = rs2_i;
      s1_f3_d    = funct3_i;
      s1_f7_d    = funct7_i;
      s1_imm_d   = imm_i[31:0];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= FMT_BAD;
      s1_err_q   <= 1'b0;
      s1_op_q    <= 7'd0;
      s1_rd_q    <= 5'd0;
      s1_rs1_q   <= 5'd0;
      s1_rs2_q   <= 5'd0;
      s1_f3_q    <= 3'd0;
      s1_f7_q    <= 7'd0;
      s1_imm_q   <= 32'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_err_q   <= s1_err_d;
      s1_op_q    <= s1_op_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_f3_q    <= s1_f3_d;
      s1_f7_q    <= s1_f7_d;
      s1_imm_q   <= s1_imm_d;
    end
  end

  // Pack the stage-1 fields; fields a format does not use are left at zero
  always_comb begin
    insn_asm = INSN_NOP;
    case (s1_fmt_q)
      FMT_R: insn_asm = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I: insn_asm = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S: insn_asm = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                         s1_imm_q[4:0], s1_op_q};
      FMT_B: insn_asm = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                         s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FMT_U: insn_asm = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FMT_J: insn_asm = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_rd_q, s1_op_q};
      default: insn_asm = INSN_NOP;
    endcase
  end

  // Stage 2 next state: the output word only changes when the output slot is free or being consumed
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_insn_d  = s2_insn_q;
    s2_err_d   = s2_err_q;
    if (en2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_insn_d = insn_asm;
        s2_err_d  = s1_err_q;
      end
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_insn_q  <= 32'd0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_insn_q  <= s2_insn_d;
      s2_err_q   <= s2_err_d;
    end
  end

  // Status next state: a handshake in the same cycle as clear takes priority over the clear
  always_comb begin
    enc_count_d  = enc_count_q;
    err_sticky_d = err_sticky_q;
    if (out_hs) begin
      enc_count_d  = clr_i ? 32'd1 : enc_count_q + 32'd1;
      err_sticky_d = clr_i ? s2_err_q : (err_sticky_q || s2_err_q);
    end else if (clr_i) begin
      enc_count_d  = 32'd0;
      err_sticky_d = 1'b0;
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_q  <= 32'd0;
      err_sticky_q <= 1'b0;
    end else begin
      enc_count_q  <= enc_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule
